// File: rtl/wb_timer.sv
// Wishbone classic timer: prescaled 32-bit counter with compare match, auto-reload and level irq.
// Every access is acked (or errored) the cycle after acceptance; no wait states, one access in flight.
module wb_timer #(
  parameter int          ADDR_WIDTH     = 32,
  parameter logic [15:0] PRESCALE_RESET = 16'h0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  input  logic [3:0]            wb_sel_i,
  input  logic                  wb_we_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic [2:0]            wb_cti_i,
  input  logic [1:0]            wb_bte_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic                  wb_rty_o,
  output logic                  irq_o
);

  logic [2:0]  ctrl;
  logic [15:0] prescale;
  logic [15:0] pcnt;
  logic [31:0] count;
  logic [31:0] compare;
  logic [1:0]  status;

  logic [2:0]  off;
  logic        req;
  logic        mapped;
  logic        wr;
  logic        tick;
  logic        tick_eff;
  logic        cnt_match;
  logic        cnt_wrap;
  logic [31:0] rdata;
  logic [31:0] wdata;
  logic [1:0]  flag_set;
  logic [1:0]  w1c;
  logic        unused_ok;

  assign off       = wb_adr_i[4:2];
  assign req       = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
  assign mapped    = (off <= 3'd4);
  assign wr        = req & wb_we_i & mapped;
  assign tick      = ctrl[0] & (pcnt == prescale);
  assign cnt_match = (count == compare);
  assign cnt_wrap  = (count == 32'hFFFF_FFFF);
  // A bus write to COUNT swallows a coincident tick, including its flag side effects.
  assign tick_eff  = tick & ~(wr & (off == 3'd2));

  assign flag_set[0] = tick_eff & cnt_match;
  assign flag_set[1] = tick_eff & cnt_wrap & ~(cnt_match & ctrl[2]);
  assign w1c         = (wr && off == 3'd4 && wb_sel_i[0]) ? wb_dat_i[1:0] : 2'b00;

  assign irq_o     = ctrl[1] & (|status);
  assign wb_rty_o  = 1'b0;
  assign unused_ok = ^{wb_cti_i, wb_bte_i, wb_adr_i};

  always_comb begin
    rdata = '0;
    case (off)
      3'd0:    rdata = {29'd0, ctrl};
      3'd1:    rdata = {16'd0, prescale};
      3'd2:    rdata = count;
      3'd3:    rdata = compare;
      3'd4:    rdata = {30'd0, status};
      default: rdata = '0;
    endcase
  end

  // Byte-lane merge of write data over the current register contents.
  always_comb begin
    wdata = rdata;
    for (int b = 0; b < 4; b++) begin
      if (wb_sel_i[b]) wdata[8*b +: 8] = wb_dat_i[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_dat_o <= '0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      ctrl     <= '0;
      prescale <= PRESCALE_RESET;
      pcnt     <= '0;
      count    <= '0;
      compare  <= 32'hFFFF_FFFF;
      status   <= '0;
    end else begin
      wb_ack_o <= req & mapped;
      wb_err_o <= req & ~mapped;
      if (req) wb_dat_o <= rdata;

      if ((wr && off == 3'd1) || !ctrl[0] || tick) pcnt <= '0;
      else                                        pcnt <= pcnt + 16'd1;

      if (wr && off == 3'd0) ctrl     <= wdata[2:0];
      if (wr && off == 3'd1) prescale <= wdata[15:0];
      if (wr && off == 3'd3) compare  <= wdata;

      if (wr && off == 3'd2)  count <= wdata;
      else if (tick)          count <= (cnt_match && ctrl[2]) ? 32'd0 : count + 32'd1;

      status <= (status & ~w1c) | flag_set;
    end
  end

endmodule

// File: tb/tb_wb_timer.sv
// Randomised scoreboard bench for wb_timer against a tick-level reference model.
module tb_wb_timer;

  localparam logic [15:0] PRE_RST = 16'h0005;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_we_i = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic [2:0]  wb_cti_i = '0;
  logic [1:0]  wb_bte_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic        wb_rty_o;
  logic        irq_o;

  wb_timer #(.ADDR_WIDTH(32), .PRESCALE_RESET(PRE_RST)) dut (
    .clk(clk), .rst_n(rst_n), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  longint cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // ---------------- reference model: register file advanced tick by tick ----------------
  logic [2:0]  m_ctrl;
  logic [15:0] m_pre;
  logic [31:0] m_cnt;
  logic [31:0] m_cmp;
  logic [1:0]  m_st;
  longint      base_edge;   // edge from which the prescale period is measured
  longint      done_edge;   // last edge whose effects the model has applied

  function automatic void model_reset();
    m_ctrl = '0; m_pre = PRE_RST; m_cnt = '0; m_cmp = 32'hFFFF_FFFF; m_st = '0;
    base_edge = cyc_cnt; done_edge = cyc_cnt;
  endfunction

  function automatic bit tick_at(longint e);
    return m_ctrl[0] && e > base_edge && ((e - base_edge) % (longint'(m_pre) + 1)) == 0;
  endfunction

  function automatic logic [1:0] do_tick();
    logic [1:0] s;
    s = '0;
    if (m_cnt == m_cmp) s[0] = 1'b1;
    if (m_cnt == m_cmp && m_ctrl[2]) m_cnt = 32'd0;
    else begin
      if (m_cnt == 32'hFFFF_FFFF) s[1] = 1'b1;
      m_cnt = m_cnt + 32'd1;
    end
    m_st = m_st | s;
    return s;
  endfunction

  function automatic void catch_up(longint e);
    if (m_ctrl[0])
      for (longint k = done_edge + 1; k < e; k++)
        if (tick_at(k)) void'(do_tick());
    if (e - 1 > done_edge) done_edge = e - 1;
  endfunction

  function automatic void model_op(input longint e, input logic [2:0] off, input bit we,
                                   input logic [31:0] dat, input logic [3:0] sel,
                                   output logic [31:0] rd);
    logic [1:0]  set;
    logic [31:0] nv;
    bit          t;
    catch_up(e);
    case (off)
      3'd0: rd = {29'd0, m_ctrl};
      3'd1: rd = {16'd0, m_pre};
      3'd2: rd = m_cnt;
      3'd3: rd = m_cmp;
      3'd4: rd = {30'd0, m_st};
      default: rd = '0;
    endcase
    t = tick_at(e);
    set = '0;
    if (t && !(we && off == 3'd2)) set = do_tick();
    if (we && off <= 3'd4) begin
      nv = rd;
      for (int b = 0; b < 4; b++) if (sel[b]) nv[8*b +: 8] = dat[8*b +: 8];
      case (off)
        3'd0: begin if (!m_ctrl[0] && nv[0]) base_edge = e; m_ctrl = nv[2:0]; end
        3'd1: begin m_pre = nv[15:0]; base_edge = e; end
        3'd2: m_cnt = nv;
        3'd3: m_cmp = nv;
        default: if (sel[0]) m_st = (m_st & ~dat[1:0]) | set;
      endcase
    end
    done_edge = e;
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    bit          err;
    bit          chk;
    logic [31:0] dat;
    longint      edge_n;
  } exp_t;
  exp_t exp_q[$];

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && (wb_ack_o || wb_err_o)) begin
      if (exp_q.size() == 0) check("unexpected_resp", {30'd0, wb_err_o, wb_ack_o}, 32'd0);
      else begin
        e = exp_q.pop_front();
        check("resp_kind", {30'd0, wb_err_o, wb_ack_o}, {30'd0, e.err, !e.err});
        check("resp_cycle", 32'(cyc_cnt - e.edge_n), 32'd0);
        if (e.chk) check("rdata", wb_dat_o, e.dat);
      end
    end
  end

  // Called at a negedge; returns at a negedge two cycles later.
  task automatic bus(input logic [2:0] off, input bit we, input logic [31:0] dat,
                     input logic [3:0] sel, input bit use_lit, input logic [31:0] lit);
    longint      e;
    logic [31:0] rd;
    logic [31:0] a;
    exp_t        x;
    e = cyc_cnt + 1;
    model_op(e, off, we, dat, sel, rd);
    x.err = (off > 3'd4);
    x.chk = !we || (off > 3'd4);
    x.dat = use_lit ? lit : rd;
    x.edge_n = e;
    exp_q.push_back(x);
    a = $urandom();
    a[4:2] = off;
    wb_adr_i = a; wb_dat_i = dat; wb_sel_i = sel; wb_we_i = we;
    wb_cti_i = 3'($urandom_range(0, 7)); wb_bte_i = 2'($urandom_range(0, 3));
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] dat);
    bus(off, 1'b1, dat, 4'hF, 1'b0, 32'd0);
  endtask
  task automatic rd(input logic [2:0] off);
    bus(off, 1'b0, $urandom(), 4'($urandom_range(0, 15)), 1'b0, 32'd0);
  endtask
  task automatic rd_lit(input logic [2:0] off, input logic [31:0] lit);
    bus(off, 1'b0, 32'd0, 4'hF, 1'b1, lit);
  endtask
  task automatic check_irq(input string name);
    catch_up(cyc_cnt + 1);
    check(name, {31'd0, irq_o}, {31'd0, (m_ctrl[1] && m_st != 2'b00)});
  endtask
  task automatic align_tick();
    while (((cyc_cnt + 1 - base_edge) % (longint'(m_pre) + 1)) != 0) @(negedge clk);
  endtask
  task automatic reset_reads();
    rd_lit(3'd0, 32'd0);
    rd_lit(3'd1, {16'd0, PRE_RST});
    rd_lit(3'd2, 32'd0);
    rd_lit(3'd3, 32'hFFFF_FFFF);
    rd_lit(3'd4, 32'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    longint      e0;
    int          n;
    logic [31:0] v;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_outputs", {29'd0, wb_ack_o, wb_err_o, irq_o}, 32'd0);
    check("reset_dat", wb_dat_o, 32'd0);
    check("rty_tied", {31'd0, wb_rty_o}, 32'd0);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    reset_reads();

    // byte-lane write over reset COMPARE
    bus(3'd3, 1'b1, 32'hAABB_CCDD, 4'b0101, 1'b0, 32'd0);
    rd_lit(3'd3, 32'hFFBB_FFDD);

    // prescaled match with auto-reload
    wr(3'd3, 32'd5);
    wr(3'd1, 32'd3);
    e0 = cyc_cnt + 1;
    wr(3'd0, 32'd7);
    n = 0;
    while (!irq_o && n < 60) begin @(negedge clk); n++; end
    check("match_latency", 32'(cyc_cnt - e0), 32'd24);
    rd_lit(3'd2, 32'd0);
    bus(3'd4, 1'b1, 32'd1, 4'hF, 1'b0, 32'd0);
    check("irq_after_w1c", {31'd0, irq_o}, 32'd0);
    wr(3'd0, 32'd0);

    // overflow
    wr(3'd2, 32'hFFFF_FFFF);
    wr(3'd1, 32'd0);
    wr(3'd3, 32'h10);
    wr(3'd4, 32'd3);
    wr(3'd0, 32'd3);
    check("irq_on_ovf", {31'd0, irq_o}, 32'd1);
    rd_lit(3'd4, 32'd2);
    rd(3'd2);
    wr(3'd0, 32'd0);

    // unmapped accesses: err, no change
    wr(3'd5, 32'hFFFF_FFFF);
    rd(3'd6);
    bus(3'd7, 1'b1, 32'h1234_5678, 4'hF, 1'b0, 32'd0);
    for (int i = 0; i < 5; i++) rd(3'(i));

    // COUNT write colliding with a tick
    wr(3'd1, 32'd3);
    wr(3'd0, 32'd1);
    align_tick();
    wr(3'd2, 32'h1234_5678);
    rd_lit(3'd2, 32'h1234_5678);

    // W1C colliding with MATCH set
    wr(3'd0, 32'd0);
    wr(3'd2, 32'd5);
    wr(3'd3, 32'd5);
    wr(3'd4, 32'd3);
    wr(3'd0, 32'd1);
    align_tick();
    wr(3'd4, 32'd1);
    rd_lit(3'd4, 32'd1);
    wr(3'd0, 32'd0);

    // randomised traffic
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 9))
        0: wr(3'd1, 32'($urandom_range(0, 3)));
        1: begin catch_up(cyc_cnt + 1); v = m_cnt + 32'($urandom_range(0, 12)); wr(3'd3, v); end
        2: begin
             if ($urandom_range(0, 3) == 0) v = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
             else v = 32'($urandom_range(0, 50));
             wr(3'd2, v);
           end
        3: wr(3'd0, 32'($urandom_range(0, 7)));
        4: bus(3'd4, 1'b1, $urandom(), 4'($urandom_range(0, 15)), 1'b0, 32'd0);
        5: bus(3'($urandom_range(0, 7)), 1'b1, $urandom(), 4'($urandom_range(0, 15)), 1'b0, 32'd0);
        default: rd(3'($urandom_range(0, 7)));
      endcase
      repeat ($urandom_range(0, 5)) @(negedge clk);
      check_irq("irq_rand");
    end

    // reset during an active count with an ack pending
    wr(3'd1, 32'd0);
    wr(3'd3, 32'h100);
    wr(3'd2, 32'hFFFF_FFFE);
    wr(3'd4, 32'd3);
    wr(3'd0, 32'd3);
    repeat (3) @(negedge clk);
    check_irq("irq_before_reset");
    wb_adr_i = 32'h0000_0008; wb_we_i = 1'b0; wb_sel_i = 4'hF;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge clk);
    #1;
    check("ack_before_reset", {31'd0, wb_ack_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("outputs_in_reset", {29'd0, wb_ack_o, wb_err_o, irq_o}, 32'd0);
    check("dat_in_reset", wb_dat_o, 32'd0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    reset_reads();
    check_irq("irq_after_reset");

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
